mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences data-memory accesses for the MEM stage. Consumes mem_write/mem_read/branch
//  from the EX/MEM control latch and drives a req/ack memory port. Asserts stall to
//  freeze PC and pipeline latches until the access completes, and pulses flush on a
//  taken branch. Sits between the EX/MEM latch and the data memory.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  TIMEOUT  15  max ACCESS cycles without mem_ack before abort (1..2^CNT_W-1)
//  CNT_W    4   wait-counter width
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-low
//  mem_write    in   1       store request (registered, from EX/MEM latch)
//  mem_read     in   1       load request (registered, from EX/MEM latch)
//  branch       in   1       taken branch resolved in MEM (registered)
//  addr         in   ADDR_W  effective address
//  wdata        in   DATA_W  store data
//  mem_req      out  1       memory request, held until ack or timeout
//  mem_we       out  1       1 = write, 0 = read; valid while mem_req
//  mem_addr     out  ADDR_W  captured address
//  mem_wdata    out  DATA_W  captured store data
//  mem_ack      in   1       memory completion, single-cycle pulse
//  mem_rdata    in   DATA_W  load data, valid with mem_ack
//  rdata        out  DATA_W  registered load result
//  rdata_valid  out  1       one-cycle strobe, load result ready
//  stall        out  1       freeze PC and pipeline latches
//  flush        out  1       one-cycle squash of younger stages
//  mem_err      out  1       sticky timeout flag
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, cnt=0. mem_req, mem_we, mem_addr, mem_wdata,
//   rdata, rdata_valid, mem_err = 0. Asserting reset mid-access drops mem_req at once.
//   A later mem_ack is ignored.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE: if mem_read|mem_write: capture addr/wdata into mem_addr/mem_wdata.
//     mem_we <= mem_write. cnt <= 0. Go to ACCESS.
//     Write has priority if both are set.
//  - ACCESS: mem_req=1 (registered). cnt increments each cycle.
//     On mem_ack: if !mem_we, rdata <= mem_rdata. Go to DONE.
//     If cnt==TIMEOUT-1 and no ack: mem_err <= 1, rdata <= 0, go to DONE.
//     An ack in the same cycle as the timeout wins (normal completion).
//  - DONE: mem_req=0. rdata_valid=1 (read only). Inputs ignored.
//     Go to IDLE next cycle. The latch advances at the end of this cycle.
//  stall (combinational) = (IDLE & (mem_read|mem_write)) | ACCESS.
//  flush (combinational) = branch & IDLE & !(mem_read|mem_write).
//  Latency: zero-wait memory (ack in the first ACCESS cycle) gives 2 stall cycles.
//   rdata_valid is high in the cycle stall falls.
//  mem_ack outside ACCESS is ignored.
//  mem_err clears only on reset.
//  No new access can start in DONE. Back-to-back ops therefore incur 1 DONE cycle each.
// TESTING
//  1. Read, addr=0x40, ack in first ACCESS cycle, rdata=0xDEADBEEF
//     -> stall high 2 cycles; mem_req 1 cycle with mem_we=0, mem_addr=0x40;
//     rdata_valid=1 and rdata=0xDEADBEEF in the cycle stall falls.
//  2. Write, addr=0x10, wdata=0x1234, ack after 3 ACCESS cycles
//     -> mem_we=1 and mem_req high 3 cycles; stall high 4 cycles; rdata_valid stays 0.
//  3. Read with no ack, TIMEOUT=15
//     -> mem_req high 15 cycles, then mem_err=1 (sticky), rdata=0, stall released.
//  4. branch=1 with no mem op -> flush=1 for that cycle, stall=0.
//     mem_read and mem_write both 1 -> write performed (mem_we=1).
//  5. rst pulled low during ACCESS cycle 2 -> all outputs 0 immediately;
//     ack arriving after reset release is ignored; FSM stays in IDLE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: turns EX/MEM load/store requests into a
// req/ack memory transaction, stalling the pipeline and flushing on taken branches.
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              branch,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic              flush,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             op_req;
  logic             timeout_hit;
  logic             stall_raw;
  logic             flush_raw;

  assign op_req      = mem_read | mem_write;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1)) & ~mem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    flush_raw = 1'b0;
    case (state)
      IDLE: begin
        if (op_req) begin
          stall_raw = 1'b1;
          state_nxt = ACCESS;
        end else begin
          flush_raw = branch;
        end
      end
      ACCESS: begin
        stall_raw = 1'b1;
        if (mem_ack || timeout_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Gated by reset so the pipeline sees no stall or flush while reset is held.
  assign stall = rst & stall_raw;
  assign flush = rst & flush_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (op_req) begin
            mem_addr  <= addr;
            mem_wdata <= wdata;
            mem_we    <= mem_write;
            mem_req   <= 1'b1;
            cnt       <= '0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          // An ack coincident with the last allowed cycle still completes normally.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              rdata       <= mem_rdata;
              rdata_valid <= 1'b1;
            end
          end else if (timeout_hit) begin
            mem_req     <= 1'b0;
            mem_err     <= 1'b1;
            rdata       <= '0;
            rdata_valid <= ~mem_we;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
